// File: rtl/pe_psum_accumulator.sv
// Partial-sum accumulator behind one systolic PE: unpacks lanes by precision mode,
// accumulates them with saturation over a first..last reduction, and queues results in a 2-entry FIFO.
module pe_psum_accumulator #(
    parameter int PE_OUT_W = 56,
    parameter int LANE88_W = 20,
    parameter int LANE18_W = 14,
    parameter int ACC_W    = 32,
    parameter int LEN_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PE_OUT_W-1:0]  in_data,
    input  logic                 in_first,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*ACC_W-1:0]   out_data,
    output logic                 out_mode,
    output logic [LEN_W-1:0]     out_len,
    output logic [3:0]           out_ovf,
    output logic                 proto_err
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {IDLE, ACC} state_t;

    state_t                  state, state_nx;
    logic signed [ACC_W-1:0] acc [4];
    logic signed [ACC_W-1:0] acc_nx [4];
    logic signed [ACC_W-1:0] lane [4];
    logic [ACC_W:0]          sum [4];
    logic [LEN_W-1:0]        len, len_nx;
    logic [3:0]              ovf, ovf_nx;
    logic                    cur_mode, beat_mode;
    logic                    accept, opening, push, pop, proto_hit;
    logic [4*ACC_W-1:0]      push_data;

    logic [4*ACC_W-1:0]      f_data [2];
    logic                    f_mode [2];
    logic [LEN_W-1:0]        f_len  [2];
    logic [3:0]              f_ovf  [2];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              count;

    assign in_ready  = (count < 2'd2);
    assign accept    = in_valid && in_ready;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;

    // A beat opens a reduction when nothing is open or when it carries in_first;
    // only an opening beat samples the mode input.
    always_comb begin
        opening   = (state == IDLE) || in_first;
        beat_mode = opening ? mode : cur_mode;
        for (int k = 0; k < 4; k++) lane[k] = '0;
        if (!beat_mode) begin
            lane[0] = ACC_W'(signed'(in_data[0 +: LANE88_W]));
            lane[1] = ACC_W'(signed'(in_data[LANE88_W +: LANE88_W]));
        end else begin
            for (int k = 0; k < 4; k++) lane[k] = ACC_W'(signed'(in_data[k*LANE18_W +: LANE18_W]));
        end
    end

    // Sums carry one guard bit; a guard/sign disagreement means the lane overflowed.
    always_comb begin
        state_nx  = state;
        len_nx    = len;
        ovf_nx    = ovf;
        push      = 1'b0;
        proto_hit = 1'b0;
        push_data = '0;
        for (int k = 0; k < 4; k++) begin
            acc_nx[k] = acc[k];
            sum[k]    = {acc[k][ACC_W-1], acc[k]} + {lane[k][ACC_W-1], lane[k]};
        end
        if (accept) begin
            proto_hit = (state == IDLE) ? !in_first : in_first;
            if (opening) begin
                for (int k = 0; k < 4; k++) acc_nx[k] = lane[k];
                len_nx = LEN_W'(1);
                ovf_nx = '0;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (sum[k][ACC_W] != sum[k][ACC_W-1]) begin
                        acc_nx[k] = sum[k][ACC_W] ? ACC_MIN : ACC_MAX;
                        ovf_nx[k] = 1'b1;
                    end else begin
                        acc_nx[k] = signed'(sum[k][ACC_W-1:0]);
                    end
                end
                len_nx = (&len) ? len : len + 1'b1;
            end
            if (in_last) begin
                push     = 1'b1;
                state_nx = IDLE;
            end else begin
                state_nx = ACC;
            end
        end
        for (int k = 0; k < 4; k++) push_data[k*ACC_W +: ACC_W] = acc_nx[k];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            len       <= '0;
            ovf       <= '0;
            cur_mode  <= 1'b0;
            proto_err <= 1'b0;
            for (int k = 0; k < 4; k++) acc[k] <= '0;
        end else begin
            state <= state_nx;
            len   <= len_nx;
            ovf   <= ovf_nx;
            for (int k = 0; k < 4; k++) acc[k] <= acc_nx[k];
            if (accept) cur_mode <= beat_mode;
            if (proto_hit) proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            f_data[wr_ptr] <= push_data;
            f_mode[wr_ptr] <= beat_mode;
            f_len[wr_ptr]  <= len_nx;
            f_ovf[wr_ptr]  <= ovf_nx;
        end
    end

    assign out_data = out_valid ? f_data[rd_ptr] : '0;
    assign out_mode = out_valid ? f_mode[rd_ptr] : 1'b0;
    assign out_len  = out_valid ? f_len[rd_ptr]  : '0;
    assign out_ovf  = out_valid ? f_ovf[rd_ptr]  : '0;

endmodule

// File: tb/tb_pe_psum_accumulator.sv
// Self-checking bench for pe_psum_accumulator: directed scenarios plus randomized reductions,
// with results compared against an arithmetic reference model through a scoreboard queue.
module tb_pe_psum_accumulator;

    localparam longint ACC_MAXV = 64'sd2147483647;
    localparam longint ACC_MINV = -64'sd2147483648;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         mode = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [55:0]  in_data = '0;
    logic         in_first = 1'b0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] out_data;
    logic         out_mode;
    logic [15:0]  out_len;
    logic [3:0]   out_ovf;
    logic         proto_err;

    pe_psum_accumulator dut (
        .clk(clk), .reset(reset), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_first(in_first), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode), .out_len(out_len),
        .out_ovf(out_ovf), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic         mode;
        logic [15:0]  len;
        logic [3:0]   ovf;
    } res_t;

    res_t       exp_q[$];
    longint     m_acc [4];
    int         m_len;
    logic [3:0] m_ovf;
    logic       m_mode;
    bit         m_open = 0;
    logic       m_proto = 1'b0;
    bit         auto_drain = 0;
    int         checks = 0;
    int         failures = 0;

    task automatic check_output(string tag, logic [127:0] obs, logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [55:0] pack14(int a, int b, int c, int d);
        return {14'(d), 14'(c), 14'(b), 14'(a)};
    endfunction

    function automatic logic [55:0] pack20(int a, int b, logic [15:0] top);
        return {top, 20'(b), 20'(a)};
    endfunction

    // Signed value of lane k as the PE packed it, for the given precision mode.
    function automatic longint lane_val(logic [55:0] d, logic md, int k);
        longint x;
        if (!md) begin
            if (k >= 2) return 0;
            x = longint'((d >> (k * 20)) & 56'hFFFFF);
            if (x >= 524288) x -= 1048576;
        end else begin
            x = longint'((d >> (k * 14)) & 56'h3FFF);
            if (x >= 8192) x -= 16384;
        end
        return x;
    endfunction

    task automatic model_accept(logic [55:0] d, logic f, logic l, logic md);
        bit     opening;
        longint s;
        res_t   r;
        opening = !m_open || f;
        if (m_open == f) m_proto = 1'b1;
        if (opening) begin
            m_mode = md;
            m_len  = 1;
            m_ovf  = '0;
            for (int k = 0; k < 4; k++) m_acc[k] = lane_val(d, md, k);
        end else begin
            for (int k = 0; k < 4; k++) begin
                s = m_acc[k] + lane_val(d, m_mode, k);
                if (s > ACC_MAXV) begin s = ACC_MAXV; m_ovf[k] = 1'b1; end
                else if (s < ACC_MINV) begin s = ACC_MINV; m_ovf[k] = 1'b1; end
                m_acc[k] = s;
            end
            if (m_len < 65535) m_len++;
        end
        m_open = 1;
        if (l) begin
            for (int k = 0; k < 4; k++) r.data[k*32 +: 32] = m_acc[k][31:0];
            r.mode = m_mode;
            r.len  = m_len[15:0];
            r.ovf  = m_ovf;
            exp_q.push_back(r);
            m_open = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(logic [55:0] d, logic f, logic l, logic md);
        int guard;
        in_valid = 1'b1;
        in_data  = d;
        in_first = f;
        in_last  = l;
        mode     = md;
        guard    = 0;
        while (!in_ready && guard < 200) begin
            if (auto_drain) out_ready = 1'b1;
            step();
            guard++;
        end
        checks++;
        assert (guard < 200) else begin
            failures++;
            $error("[TB] FAIL beat_accept_timeout observed=in_ready_low expected=in_ready_high");
        end
        model_accept(d, f, l, md);
        step();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    // Scoreboard: every popped head must match the oldest outstanding model result.
    always @(negedge clk) begin
        res_t e;
        if (!reset && out_valid && out_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("[TB] FAIL unexpected_result observed=out_valid expected=no_result");
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_output("sb_out_data", out_data, e.data);
                check_output("sb_out_mode", out_mode, e.mode);
                check_output("sb_out_len", out_len, e.len);
                check_output("sb_out_ovf", out_ovf, e.ovf);
            end
        end
    end

    initial begin
        logic [63:0] rnd;
        int          n;
        logic        rmode;

        repeat (3) step();
        reset = 1'b0;
        check_output("rst_out_valid", out_valid, 1'b0);
        check_output("rst_in_ready", in_ready, 1'b1);
        check_output("rst_proto_err", proto_err, 1'b0);
        check_output("rst_out_data", out_data, 128'd0);

        $display("[TB] mode 1 three-beat reduction");
        out_ready = 1'b1;
        apply_stimulus(pack14(1, 2, 3, 4), 1'b1, 1'b0, 1'b1);
        check_output("t1_no_valid_b1", out_valid, 1'b0);
        apply_stimulus(pack14(-1, -1, -1, -1), 1'b0, 1'b0, 1'b1);
        check_output("t1_no_valid_b2", out_valid, 1'b0);
        apply_stimulus(pack14(10, 0, -5, 7), 1'b0, 1'b1, 1'b1);
        check_output("t1_valid_latency", out_valid, 1'b1);
        check_output("t1_data", out_data, {32'd10, 32'hFFFFFFFD, 32'd1, 32'd10});
        check_output("t1_len", out_len, 16'd3);
        check_output("t1_mode", out_mode, 1'b1);
        check_output("t1_ovf", out_ovf, 4'd0);
        step();
        check_output("t1_single_result", out_valid, 1'b0);

        $display("[TB] mode 0 single-beat extremes");
        apply_stimulus(pack20(-524288, 524287, 16'hFFFF), 1'b1, 1'b1, 1'b0);
        check_output("t2_data", out_data, {32'd0, 32'd0, 32'd524287, 32'hFFF80000});
        check_output("t2_len", out_len, 16'd1);
        check_output("t2_mode", out_mode, 1'b0);
        step();

        $display("[TB] saturation over 4200 beats");
        for (int i = 0; i < 4200; i++)
            apply_stimulus(pack20(524287, 0, 16'h0), i == 0, i == 4199, 1'b0);
        check_output("t3_sat_lane0", out_data[31:0], 32'h7FFFFFFF);
        check_output("t3_sat_ovf", out_ovf, 4'b0001);
        check_output("t3_sat_len", out_len, 16'd4200);
        step();
        apply_stimulus(pack20(3, -4, 16'h0), 1'b1, 1'b0, 1'b0);
        apply_stimulus(pack20(1, 1, 16'h0), 1'b0, 1'b1, 1'b0);
        check_output("t3_clean_ovf", out_ovf, 4'd0);
        check_output("t3_clean_data", out_data[63:0], {32'hFFFFFFFD, 32'd4});
        step();

        $display("[TB] back-pressure with full FIFO");
        out_ready = 1'b0;
        apply_stimulus(pack20(5, 0, 16'h0), 1'b1, 1'b1, 1'b0);
        apply_stimulus(pack20(6, 0, 16'h0), 1'b1, 1'b1, 1'b0);
        check_output("t4_full_ready", in_ready, 1'b0);
        check_output("t4_full_valid", out_valid, 1'b1);
        in_valid = 1'b1;
        in_data  = pack20(7, 0, 16'h0);
        in_first = 1'b1;
        in_last  = 1'b1;
        repeat (3) begin
            step();
            check_output("t4_stall_ready", in_ready, 1'b0);
            check_output("t4_head_stable", out_data[31:0], 32'd5);
        end
        out_ready = 1'b1;
        apply_stimulus(pack20(7, 0, 16'h0), 1'b1, 1'b1, 1'b0);
        repeat (4) step();
        check_output("t4_drained", exp_q.size(), 0);
        check_output("t4_empty", out_valid, 1'b0);

        $display("[TB] protocol errors");
        check_output("t5_proto_clear", proto_err, 1'b0);
        apply_stimulus(pack14(100, 100, 100, 100), 1'b0, 1'b0, 1'b1);
        check_output("t5_proto_idle", proto_err, 1'b1);
        apply_stimulus(pack14(50, 50, 50, 50), 1'b0, 1'b0, 1'b1);
        apply_stimulus(pack14(1, 2, 3, 4), 1'b1, 1'b0, 1'b1);
        apply_stimulus(pack14(1, 1, 1, 1), 1'b0, 1'b1, 1'b1);
        check_output("t5_restart_len", out_len, 16'd2);
        check_output("t5_restart_data", out_data, {32'd5, 32'd4, 32'd3, 32'd2});
        check_output("t5_proto_sticky", proto_err, 1'b1);
        step();

        $display("[TB] reset mid-reduction");
        out_ready = 1'b0;
        apply_stimulus(pack20(3, 0, 16'h0), 1'b1, 1'b1, 1'b0);
        apply_stimulus(pack20(11, 0, 16'h0), 1'b1, 1'b0, 1'b0);
        apply_stimulus(pack20(12, 0, 16'h0), 1'b0, 1'b0, 1'b0);
        check_output("t6_pending", out_valid, 1'b1);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = pack20(77, 0, 16'h0);
        in_first = 1'b1;
        in_last  = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        exp_q.delete();
        m_open  = 0;
        m_proto = 1'b0;
        check_output("t6_rst_valid", out_valid, 1'b0);
        check_output("t6_rst_ready", in_ready, 1'b1);
        check_output("t6_rst_data", out_data, 128'd0);
        check_output("t6_rst_len", out_len, 16'd0);
        check_output("t6_rst_mode", out_mode, 1'b0);
        check_output("t6_rst_ovf", out_ovf, 4'd0);
        check_output("t6_rst_proto", proto_err, 1'b0);
        step();
        check_output("t6_reset_beat_dropped", out_valid, 1'b0);
        out_ready = 1'b1;
        apply_stimulus(pack20(9, 0, 16'h0), 1'b1, 1'b1, 1'b0);
        check_output("t6_after_data", out_data, {96'd0, 32'd9});
        check_output("t6_after_len", out_len, 16'd1);
        step();

        $display("[TB] randomized reductions");
        auto_drain = 1;
        for (int r = 0; r < 40; r++) begin
            n     = $urandom_range(1, 5);
            rmode = 1'($urandom_range(0, 1));
            for (int b = 0; b < n; b++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                rnd = {$urandom, $urandom};
                apply_stimulus(rnd[55:0], b == 0, b == n - 1,
                               (b == 0) ? rmode : 1'($urandom_range(0, 1)));
            end
        end
        out_ready = 1'b1;
        repeat (5) step();
        check_output("t7_drained", exp_q.size(), 0);
        check_output("t7_empty", out_valid, 1'b0);
        check_output("t7_proto", proto_err, m_proto);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
